// File: rtl/i2c_bridge_pkg.sv
// Shared types and constants for the I2C bridge direction controller.
package i2c_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdAck,
    StWaitStop
  } state_e;

  localparam logic SDA_DIR_M2S = 1'b0;
  localparam logic SDA_DIR_S2M = 1'b1;
  localparam logic ACK         = 1'b0;
  localparam logic NACK        = 1'b1;

  // Forwarding direction owned by each protocol phase.
  function automatic logic state_dir(input state_e st);
    case (st)
      StAddrAck, StWrAck, StRdData: return SDA_DIR_S2M;
      default:                      return SDA_DIR_M2S;
    endcase
  endfunction

endpackage

// File: rtl/i2c_bridge_dir_ctrl_line_filter.sv
// i2c_line_filter: synchroniser chain followed by a stability filter.
// The filtered level follows the synchronised level only after it has
// differed for GLITCH_CYCLES consecutive clocks. Resets to 1 (idle bus).
module i2c_line_filter #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned GLITCH_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int unsigned CntW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign level  = filt_q;

  // Synchroniser chain, oldest sample at the top.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Count consecutive cycles of disagreement; accept on the last one.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (synced != filt_q) begin
      if (cnt_q == CntW'(GLITCH_CYCLES - 1)) begin
        filt_d = synced;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

endmodule

// File: rtl/i2c_bridge_dir_ctrl.sv
// I2C bridge direction controller: tracks START/address/ACK/data/STOP on the
// filtered pins and decides which side drives SDA for each bit.
// Optional address filtering is enabled by defining I2C_BRIDGE_ADDR_FILTER_EN.
module i2c_bridge_dir_ctrl
  import i2c_bridge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned GLITCH_CYCLES  = 3,
  parameter int unsigned TIMEOUT_CYCLES = 100000
`ifdef I2C_BRIDGE_ADDR_FILTER_EN
  , parameter logic [6:0] ADDR_VALUE    = 7'h50,
  parameter logic [6:0] ADDR_MASK       = 7'h7F
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic m_scl_in,
  input  logic m_sda_in,
  input  logic s_sda_in,
  output logic sda_dir,
  output logic busy,
  output logic start_det,
  output logic stop_det,
  output logic rw,
  output logic nack_det,
  output logic timeout,
  output logic addr_blocked
);

  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

  logic scl, m_sda, s_sda;
  logic scl_prev_q, sda_prev_q;
  logic start_ev, stop_ev, scl_rise, scl_fall;

  state_e       state_q, state_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic         done_q, done_d;       // byte complete / ACK slot sampled
  logic         ack_q, ack_d;
  logic         rw_q, rw_d;
  logic         busy_q, busy_d;
  logic         dir_q, dir_d;
  logic         start_q, start_d, stop_q, stop_d, nack_q, nack_d, to_q, to_d;
  logic         blocked_q, blocked_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
`ifdef I2C_BRIDGE_ADDR_FILTER_EN
  logic [6:0]   addr_sr_q, addr_sr_d;
`endif

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_CYCLES(GLITCH_CYCLES)) u_scl_filt (
    .clk(clk), .reset(reset), .raw(m_scl_in), .level(scl)
  );
  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_CYCLES(GLITCH_CYCLES)) u_msda_filt (
    .clk(clk), .reset(reset), .raw(m_sda_in), .level(m_sda)
  );
  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_CYCLES(GLITCH_CYCLES)) u_ssda_filt (
    .clk(clk), .reset(reset), .raw(s_sda_in), .level(s_sda)
  );

  // START/STOP need SCL high on both sides of the SDA edge.
  assign start_ev = scl && scl_prev_q && sda_prev_q && !m_sda;
  assign stop_ev  = scl && scl_prev_q && !sda_prev_q && m_sda;
  assign scl_rise = scl && !scl_prev_q;
  assign scl_fall = !scl && scl_prev_q;

  // Protocol sequencer: START > STOP > timeout > SCL edges.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = done_q;
    ack_d     = ack_q;
    rw_d      = rw_q;
    busy_d    = busy_q;
    blocked_d = blocked_q;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    nack_d    = 1'b0;
    to_d      = 1'b0;
    to_cnt_d  = (busy_q && !scl) ? to_cnt_q + ToW'(1) : '0;
`ifdef I2C_BRIDGE_ADDR_FILTER_EN
    addr_sr_d = addr_sr_q;
`endif
    if (start_ev) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      done_d    = 1'b0;
      busy_d    = 1'b1;
      blocked_d = 1'b0;
      start_d   = 1'b1;
    end else if (stop_ev) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      done_d    = 1'b0;
      busy_d    = 1'b0;
      blocked_d = 1'b0;
      stop_d    = 1'b1;
    end else if (busy_q && !scl && to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      done_d    = 1'b0;
      busy_d    = 1'b0;
      blocked_d = 1'b0;
      to_cnt_d  = '0;
      to_d      = 1'b1;
    end else if (scl_rise) begin
      case (state_q)
        StAddr, StWrData, StRdData: begin
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (state_q == StAddr) begin
`ifdef I2C_BRIDGE_ADDR_FILTER_EN
            addr_sr_d = {addr_sr_q[5:0], m_sda};
            if (bit_cnt_q == 3'd7) begin
              blocked_d = (addr_sr_q & ADDR_MASK) != (ADDR_VALUE & ADDR_MASK);
            end
`endif
            if (bit_cnt_q == 3'd7) rw_d = m_sda;
          end
        end
        StAddrAck, StWrAck: begin
          ack_d  = s_sda;
          done_d = 1'b1;
          nack_d = (s_sda == NACK);
        end
        StRdAck: begin
          ack_d  = m_sda;
          done_d = 1'b1;
          nack_d = (m_sda == NACK);
        end
        default: ;
      endcase
    end else if (scl_fall && done_q) begin
      done_d = 1'b0;
      case (state_q)
        StAddr:    state_d = blocked_q ? StWaitStop : StAddrAck;
        StWrData:  state_d = StWrAck;
        StRdData:  state_d = StRdAck;
        StAddrAck: state_d = (ack_q == NACK) ? StWaitStop : (rw_q ? StRdData : StWrData);
        StWrAck:   state_d = (ack_q == NACK) ? StWaitStop : StWrData;
        StRdAck:   state_d = (ack_q == NACK) ? StWaitStop : StRdData;
        default: ;
      endcase
    end
    dir_d = state_dir(state_d);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      done_q     <= 1'b0;
      ack_q      <= ACK;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      dir_q      <= SDA_DIR_M2S;
      blocked_q  <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      nack_q     <= 1'b0;
      to_q       <= 1'b0;
      to_cnt_q   <= '0;
`ifdef I2C_BRIDGE_ADDR_FILTER_EN
      addr_sr_q  <= '0;
`endif
    end else begin
      scl_prev_q <= scl;
      sda_prev_q <= m_sda;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      dir_q      <= dir_d;
      blocked_q  <= blocked_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      nack_q     <= nack_d;
      to_q       <= to_d;
      to_cnt_q   <= to_cnt_d;
`ifdef I2C_BRIDGE_ADDR_FILTER_EN
      addr_sr_q  <= addr_sr_d;
`endif
    end
  end

  assign sda_dir   = dir_q;
  assign busy      = busy_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign rw        = rw_q;
  assign nack_det  = nack_q;
  assign timeout   = to_q;
`ifdef I2C_BRIDGE_ADDR_FILTER_EN
  assign addr_blocked = blocked_q;
`else
  assign addr_blocked = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bridge_dir_ctrl.sv
// Directed bench for i2c_bridge_dir_ctrl: bit-level I2C stimulus on the raw
// pins with hand-computed direction, pulse and status expectations.
module tb_i2c_bridge_dir_ctrl;

  localparam int unsigned TIMEOUT_CYCLES = 200;
  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m_scl_in = 1'b1, m_sda_in = 1'b1, s_sda_in = 1'b1;
  logic sda_dir, busy, start_det, stop_det, rw, nack_det, timeout, addr_blocked;

  int n_tests = 0, n_fail = 0;
  int n_start = 0, n_stop = 0, n_nack = 0, n_timeout = 0, n_busy_fall = 0;
  logic busy_prev = 1'b0;

  always #5 clk = ~clk;

  i2c_bridge_dir_ctrl #(
    .SYNC_STAGES(2), .GLITCH_CYCLES(3), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .m_scl_in(m_scl_in), .m_sda_in(m_sda_in),
    .s_sda_in(s_sda_in), .sda_dir(sda_dir), .busy(busy), .start_det(start_det),
    .stop_det(stop_det), .rw(rw), .nack_det(nack_det), .timeout(timeout),
    .addr_blocked(addr_blocked)
  );

  // Pulse and busy-edge counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (start_det) n_start <= n_start + 1;
    if (stop_det) n_stop <= n_stop + 1;
    if (nack_det) n_nack <= n_nack + 1;
    if (timeout) n_timeout <= n_timeout + 1;
    if (busy_prev && !busy) n_busy_fall <= n_busy_fall + 1;
    busy_prev <= busy;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda_in = 1'b1; s_sda_in = 1'b1; idle(Q);
    m_scl_in = 1'b1; idle(Q);
    m_sda_in = 1'b0; s_sda_in = 1'b0; idle(Q);
    m_scl_in = 1'b0; idle(Q);
  endtask

  task automatic bus_bit(input logic mb, input logic sb, input logic exp_dir, input string tag);
    m_sda_in = mb; s_sda_in = sb; idle(Q);
    m_scl_in = 1'b1; idle(Q);
    check_eq(tag, sda_dir, exp_dir);
    idle(Q);
    m_scl_in = 1'b0; idle(Q);
  endtask

  task automatic bus_byte(input logic [7:0] mb, input logic [7:0] sb, input logic exp_dir,
                          input string tag);
    for (int i = 7; i >= 0; i--) bus_bit(mb[i], sb[i], exp_dir, tag);
  endtask

  task automatic bus_stop();
    m_sda_in = 1'b0; s_sda_in = 1'b0; idle(Q);
    m_scl_in = 1'b1; idle(Q);
    m_sda_in = 1'b1; s_sda_in = 1'b1; idle(2 * Q);
  endtask

  initial begin
    int s0, p0, k0, t0, b0;
    idle(3);
    check_eq("rst_dir", sda_dir, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rw", rw, 0);
    check_eq("rst_pulses", {start_det, stop_det, nack_det, timeout}, 0);
    check_eq("rst_blocked", addr_blocked, 0);
    reset = 1'b0;
    idle(Q);

    // Write 0x50, data 0xA5, both ACKed.
    s0 = n_start; p0 = n_stop; k0 = n_nack;
    bus_start();
    check_eq("wr_busy", busy, 1);
    check_eq("wr_start", n_start, s0 + 1);
    bus_byte(8'hA0, 8'hA0, 1'b0, "wr_addr_dir");
    bus_bit(1'b0, 1'b0, 1'b1, "wr_addr_ack_dir");
    check_eq("wr_rw", rw, 0);
    bus_byte(8'hA5, 8'hA5, 1'b0, "wr_data_dir");
    bus_bit(1'b0, 1'b0, 1'b1, "wr_data_ack_dir");
    bus_stop();
    check_eq("wr_stop", n_stop, p0 + 1);
    check_eq("wr_start_once", n_start, s0 + 1);
    check_eq("wr_busy_end", busy, 0);
    check_eq("wr_dir_end", sda_dir, 0);
    check_eq("wr_no_nack", n_nack, k0);

    // Read 0x51, data 0x3C, controller NACKs (target side high-Z low here).
    p0 = n_stop; k0 = n_nack;
    bus_start();
    bus_byte(8'hA3, 8'hA3, 1'b0, "rd_addr_dir");
    bus_bit(1'b0, 1'b0, 1'b1, "rd_addr_ack_dir");
    check_eq("rd_rw", rw, 1);
    bus_byte(8'h3C, 8'h3C, 1'b1, "rd_data_dir");
    bus_bit(1'b1, 1'b0, 1'b0, "rd_nack_dir");
    check_eq("rd_nack", n_nack, k0 + 1);
    check_eq("rd_wait_busy", busy, 1);
    bus_bit(1'b1, 1'b1, 1'b0, "rd_wait_dir");
    bus_stop();
    check_eq("rd_stop", n_stop, p0 + 1);
    check_eq("rd_busy_end", busy, 0);

    // Address 0x22 with no target: ACK slot sampled from target side.
    p0 = n_stop; k0 = n_nack;
    bus_start();
    bus_byte(8'h44, 8'h44, 1'b0, "na_addr_dir");
    bus_bit(1'b0, 1'b1, 1'b1, "na_ack_dir");
    check_eq("na_nack", n_nack, k0 + 1);
    check_eq("na_dir_after", sda_dir, 0);
    check_eq("na_busy", busy, 1);
    bus_stop();
    check_eq("na_stop", n_stop, p0 + 1);

    // Repeated START after a write ACK, then read 0x51.
    s0 = n_start; b0 = n_busy_fall;
    bus_start();
    bus_byte(8'hA0, 8'hA0, 1'b0, "rs_addr1_dir");
    bus_bit(1'b0, 1'b0, 1'b1, "rs_ack1_dir");
    check_eq("rs_rw1", rw, 0);
    bus_start();
    check_eq("rs_start2", n_start, s0 + 2);
    bus_byte(8'hA3, 8'hA3, 1'b0, "rs_addr2_dir");
    bus_bit(1'b0, 1'b0, 1'b1, "rs_ack2_dir");
    check_eq("rs_rw2", rw, 1);
    bus_byte(8'h3C, 8'h3C, 1'b1, "rs_rd_dir");
    bus_bit(1'b1, 1'b1, 1'b0, "rs_nack_dir");
    check_eq("rs_busy_kept", n_busy_fall, b0);
    bus_stop();
    check_eq("rs_busy_end", busy, 0);

    // STOP while idle: only stop_det.
    s0 = n_start; p0 = n_stop;
    m_scl_in = 1'b0; idle(Q);
    bus_stop();
    check_eq("idle_stop", n_stop, p0 + 1);
    check_eq("idle_stop_busy", busy, 0);
    check_eq("idle_stop_nostart", n_start, s0);

    // 2-cycle SDA glitch with SCL high is rejected; 3 cycles is accepted.
    s0 = n_start; p0 = n_stop;
    m_sda_in = 1'b0; idle(2); m_sda_in = 1'b1; idle(2 * Q);
    check_eq("glitch2_start", n_start, s0);
    check_eq("glitch2_stop", n_stop, p0);
    m_sda_in = 1'b0; idle(3); m_sda_in = 1'b1; idle(2 * Q);
    check_eq("glitch3_start", n_start, s0 + 1);
    check_eq("glitch3_stop", n_stop, p0 + 1);

    // High glitch mid-bit while busy, then SCL stuck low during read data.
    p0 = n_stop; t0 = n_timeout;
    bus_start();
    m_sda_in = 1'b0; s_sda_in = 1'b0; idle(Q);
    m_scl_in = 1'b1; idle(Q);
    m_sda_in = 1'b1; idle(2); m_sda_in = 1'b0; idle(Q);
    check_eq("glitch_hi_stop", n_stop, p0);
    check_eq("glitch_hi_busy", busy, 1);
    m_scl_in = 1'b0; idle(Q);
    for (int i = 6; i >= 0; i--) bus_bit(((i == 1) || (i == 0)), ((i == 1) || (i == 0)),
                                         1'b0, "to_addr_dir");
    bus_bit(1'b0, 1'b0, 1'b1, "to_ack_dir");
    bus_bit(1'b1, 1'b1, 1'b1, "to_rd_dir");
    bus_bit(1'b0, 1'b0, 1'b1, "to_rd_dir");
    idle(150);
    check_eq("to_early_busy", busy, 1);
    check_eq("to_early_pulse", n_timeout, t0);
    idle(100);
    check_eq("to_pulse", n_timeout, t0 + 1);
    check_eq("to_busy", busy, 0);
    check_eq("to_dir", sda_dir, 0);
    bus_stop();
    check_eq("to_idle_stop", n_stop, p0 + 1);

    // Asynchronous reset during read data, then a normal write.
    bus_start();
    bus_byte(8'hA3, 8'hA3, 1'b0, "ar_addr_dir");
    bus_bit(1'b0, 1'b0, 1'b1, "ar_ack_dir");
    bus_bit(1'b1, 1'b1, 1'b1, "ar_rd_dir");
    m_sda_in = 1'b0; s_sda_in = 1'b0; idle(Q);
    m_scl_in = 1'b1; idle(Q);
    check_eq("ar_pre_dir", sda_dir, 1);
    check_eq("ar_pre_rw", rw, 1);
    reset = 1'b1;
    #1;
    check_eq("ar_dir", sda_dir, 0);
    check_eq("ar_busy", busy, 0);
    check_eq("ar_rw", rw, 0);
    check_eq("ar_pulses", {start_det, stop_det, nack_det, timeout}, 0);
    m_sda_in = 1'b1; s_sda_in = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(Q);
    s0 = n_start;
    check_eq("ar_idle_busy", busy, 0);
    bus_start();
    check_eq("ar_restart", n_start, s0 + 1);
    check_eq("ar_restart_busy", busy, 1);
    bus_byte(8'hA0, 8'hA0, 1'b0, "ar_addr2_dir");
    bus_bit(1'b0, 1'b0, 1'b1, "ar_ack2_dir");
    check_eq("ar_rw2", rw, 0);
    bus_stop();
    check_eq("ar_busy_end", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
